uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 4, per-source FIFO depth in bytes; power of two, at least 2.
REQ-002 SHALL have port clk  in  1  system clock, 7.3728 MHz; one clock domain only.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port a_data  in  8  byte from source A, the meter path from ioexp.
REQ-005 SHALL have port a_valid  in  1  source A byte is offered.
REQ-006 SHALL have port a_ready  out  1  source A FIFO can accept a byte.
REQ-007 SHALL have ports b_data  in  8, b_valid  in  1 and b_ready  out  1, with the same meaning for source B, the local status/reply path.
REQ-008 SHALL have port data  out  8  byte presented to uart_tx.
REQ-009 SHALL have port data_valid  out  1  byte presented; level signal held until acknowledged.
REQ-010 SHALL have port tx_ack  in  1  uart_tx has captured the byte; single-cycle pulse, already synchronous to clk.
REQ-011 SHALL have port grant_src  out  1  source of the byte on data: 0 = A, 1 = B.
REQ-012 SHALL have port busy  out  1  high when not IDLE or when either FIFO is non-empty.

Function
REQ-013 SHALL implement one DEPTH-entry FIFO per source, with occupancy counters of width clog2(DEPTH)+1 and pointers that wrap modulo DEPTH.
REQ-014 SHALL drive x_ready = !full from registered state.
- A push occurs on a clk edge where x_valid & x_ready.
- No push when full, even if a pop occurs in the same cycle.
REQ-015 SHALL, on a simultaneous push and pop of the same non-full FIFO, leave the count unchanged and keep the data order.
REQ-016 SHALL implement an FSM with states IDLE, PRESENT and GAP.
REQ-017 In IDLE with at least one FIFO non-empty, the FSM SHALL do all of the following at one edge:
- pop the granted FIFO;
- load data and grant_src;
- set data_valid = 1;
- go to PRESENT.
REQ-018 Arbitration SHALL be round-robin. When both FIFOs are non-empty, grant the source not granted last; last_grant updates on every grant.
REQ-019 In PRESENT, data, data_valid and grant_src SHALL hold stable until tx_ack = 1. On the edge where tx_ack = 1, clear data_valid and go to GAP.
REQ-020 GAP SHALL last exactly one cycle with data_valid = 0, then go to IDLE, so uart_tx sees a low level between bytes.
REQ-021 tx_ack SHALL be ignored in IDLE and GAP.
REQ-022 Latency SHALL be: byte pushed into an empty FIFO at edge k while IDLE gives data_valid = 1 after edge k+1.
REQ-023 Sustained throughput SHALL be at most one byte per 3 cycles plus the tx_ack wait. Bytes from one source SHALL leave in push order, with none lost or duplicated.
REQ-024 data SHALL retain its last value in IDLE and GAP.

Reset
REQ-025 While rst = 1, the block SHALL hold all of the following immediately, without waiting for a clk edge:
- FSM = IDLE;
- both FIFOs empty, pointers 0;
- data = 8'h00, data_valid = 0, grant_src = 0;
- last_grant = 1, so A wins the first tie;
- busy = 0;
- a_ready = b_ready = 1.
REQ-026 Reset asserted mid-PRESENT SHALL discard the presented byte and all FIFO contents. After deassertion, nothing is emitted until a new push occurs.
REQ-027 Reset deassertion SHALL be synchronized by the instantiating logic; this block has no internal reset synchronizer.

Verification
REQ-028 Single byte: push A = 8'h5A into an empty block, tx_ack 4 cycles after data_valid rises. Required:
- data_valid = 1 one cycle after the push, with data = 8'h5A and grant_src = 0;
- data_valid low for exactly one cycle after tx_ack;
- busy = 0 afterwards.
REQ-029 Tie: A = 8'h11, 8'h12 and B = 8'h21, 8'h22 all queued before the first grant, tx_ack 2 cycles after each rise. Output order SHALL be 11, 21, 12, 22.
REQ-030 Full: push 5 bytes into A with tx_ack held low. Required:
- a_ready = 0 after the 4th push;
- the 5th byte is not accepted;
- after one tx_ack, a_ready = 1 again and order is preserved.
REQ-031 Push and pop on the same edge: FIFO A holds 2 bytes, a push and a pop land on the same edge. Required: count stays 2 and the FIFO order is intact.
REQ-032 Reset mid-operation: assert rst in PRESENT with 3 bytes queued. Required:
- data_valid = 0 immediately;
- after release, busy = 0 and no output occurs until a new push.
REQ-033 Stray ack: tx_ack pulsed in IDLE and in GAP. Required: no state change and no FIFO pop.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Two-source byte arbiter feeding a single uart_tx: one small FIFO per source,
// round-robin grant, and a level-valid/ack handshake with a one-cycle gap between bytes.

module uart_tx_arb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       rd_pop,
  output logic [7:0] rd_data,
  output logic       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Ready comes only from the registered count, so a pop on the same edge never frees a full slot early.
  assign wr_ready = (count != CW'(DEPTH));
  assign empty    = (count == '0);
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_pop && !empty;
  assign rd_data  = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define validity, so clearing it is wasted logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_tx_arb #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a_data,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [7:0] b_data,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       tx_ack,
  output logic       grant_src,
  output logic       busy
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  state_t     state;
  logic       last_grant;
  logic [7:0] a_head;
  logic [7:0] b_head;
  logic       a_empty;
  logic       b_empty;
  logic       a_pop;
  logic       b_pop;
  logic       grant_any;
  logic       grant_sel;

  uart_tx_arb_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (a_data),
    .wr_valid (a_valid),
    .wr_ready (a_ready),
    .rd_pop   (a_pop),
    .rd_data  (a_head),
    .empty    (a_empty)
  );

  uart_tx_arb_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (b_data),
    .wr_valid (b_valid),
    .wr_ready (b_ready),
    .rd_pop   (b_pop),
    .rd_data  (b_head),
    .empty    (b_empty)
  );

  // NOTE: combinational outputs get a default before any branch so no latch is inferred.
  always_comb begin
    grant_sel = 1'b0;
    if (!a_empty && !b_empty) grant_sel = !last_grant;
    else                      grant_sel = a_empty;
  end

  assign grant_any = !a_empty || !b_empty;
  assign a_pop     = (state == IDLE) && grant_any && !grant_sel;
  assign b_pop     = (state == IDLE) && grant_any &&  grant_sel;
  assign busy      = (state != IDLE) || grant_any;

  // last_grant resets to B so that A wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      data       <= 8'h00;
      data_valid <= 1'b0;
      grant_src  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            data       <= grant_sel ? b_head : a_head;
            grant_src  <= grant_sel;
            last_grant <= grant_sel;
            data_valid <= 1'b1;
            state      <= PRESENT;
          end
        end
        PRESENT: begin
          if (tx_ack) begin
            data_valid <= 1'b0;
            state      <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus randomized traffic,
// all compared each cycle against a queue-based reference model.

module tb_uart_tx_arb;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a_data = 8'h00;
  logic       a_valid = 1'b0;
  logic [7:0] b_data = 8'h00;
  logic       b_valid = 1'b0;
  logic       tx_ack = 1'b0;
  logic       a_ready;
  logic       b_ready;
  logic [7:0] data;
  logic       data_valid;
  logic       grant_src;
  logic       busy;

  always #5 clk = ~clk;

  uart_tx_arb #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_data     (a_data),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .b_data     (b_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .data       (data),
    .data_valid (data_valid),
    .tx_ack     (tx_ack),
    .grant_src  (grant_src),
    .busy       (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes waiting per source, plus the byte currently on offer.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] emitted[$];
  logic [7:0] exp_q[$];
  bit         m_pres;
  bit         m_gap;
  bit         m_last;
  bit         m_src;
  logic [7:0] m_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_pres = 1'b0;
    m_gap  = 1'b0;
    m_last = 1'b1;
    m_src  = 1'b0;
    m_byte = 8'h00;
  endtask

  task automatic compare_outputs();
    check("data_valid", data_valid, m_pres);
    check("data", data, m_byte);
    check("grant_src", grant_src, m_src);
    check("busy", busy, m_pres || m_gap || qa.size() != 0 || qb.size() != 0);
    check("a_ready", a_ready, qa.size() < DEPTH);
    check("b_ready", b_ready, qb.size() < DEPTH);
  endtask

  // One clock: advance the model with the inputs currently driven, then compare after the edge.
  task automatic cycle();
    bit push_a;
    bit push_b;
    bit pick;
    if (!rst) begin
      if (data_valid && tx_ack) emitted.push_back(data);
      push_a = a_valid && (qa.size() < DEPTH);
      push_b = b_valid && (qb.size() < DEPTH);
      if (m_pres) begin
        if (tx_ack) begin
          m_pres = 1'b0;
          m_gap  = 1'b1;
        end
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else if (qa.size() != 0 || qb.size() != 0) begin
        if (qa.size() != 0 && qb.size() != 0) pick = !m_last;
        else                                  pick = (qa.size() == 0);
        m_byte = pick ? qb.pop_front() : qa.pop_front();
        m_src  = pick;
        m_last = pick;
        m_pres = 1'b1;
      end
      if (push_a) qa.push_back(a_data);
      if (push_b) qb.push_back(b_data);
    end
    @(posedge clk);
    #1;
    if (rst) model_reset();
    compare_outputs();
  endtask

  task automatic drive(input bit av, input logic [7:0] ad, input bit bv, input logic [7:0] bd, input bit ack);
    a_valid = av;
    a_data  = ad;
    b_valid = bv;
    b_data  = bd;
    tx_ack  = ack;
  endtask

  task automatic wait_dv(input string tag);
    int n;
    n = 0;
    while (!data_valid && n < 50) begin
      cycle();
      n++;
    end
    if (!data_valid) check({tag, "_timeout"}, data_valid, 1);
  endtask

  task automatic ack_once();
    tx_ack = 1'b1;
    cycle();
    tx_ack = 1'b0;
  endtask

  task automatic serve(input int hold);
    wait_dv("serve");
    repeat (hold) cycle();
    ack_once();
    check("gap_low", data_valid, 0);
  endtask

  task automatic check_order(input string tag);
    check({tag, "_len"}, emitted.size(), exp_q.size());
    for (int i = 0; i < emitted.size() && i < exp_q.size(); i++)
      check(tag, emitted[i], exp_q[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pa;
    int pb;
    int pk;
    int n;

    // Reset values are visible before any clock edge.
    model_reset();
    #2;
    check("rst_data", data, 8'h00);
    check("rst_dv", data_valid, 0);
    check("rst_gs", grant_src, 0);
    check("rst_busy", busy, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Single byte: valid one cycle after the push, held until ack.
    emitted.delete();
    drive(1, 8'h5A, 0, 8'h00, 0);
    cycle();
    a_valid = 1'b0;
    cycle();
    check("t1_dv", data_valid, 1);
    check("t1_data", data, 8'h5A);
    check("t1_gs", grant_src, 0);
    repeat (3) cycle();
    check("t1_hold", data_valid, 1);
    ack_once();
    check("t1_gap", data_valid, 0);
    cycle();
    check("t1_gap2", data_valid, 0);
    check("t1_busy", busy, 0);
    exp_q.delete();
    exp_q.push_back(8'h5A);
    check_order("t1_order");

    // Tie: B dummy held on output while both sources queue two bytes each.
    emitted.delete();
    drive(0, 8'h00, 1, 8'hEE, 0);
    cycle();
    b_valid = 1'b0;
    wait_dv("t2_dummy");
    drive(1, 8'h11, 1, 8'h21, 0);
    cycle();
    drive(1, 8'h12, 1, 8'h22, 0);
    cycle();
    drive(0, 8'h00, 0, 8'h00, 0);
    repeat (5) serve(2);
    repeat (3) cycle();
    check("t2_busy", busy, 0);
    exp_q.delete();
    exp_q.push_back(8'hEE);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h22);
    check_order("t2_order");

    // Full: output stalled on a B byte while five bytes are offered to A.
    emitted.delete();
    drive(0, 8'h00, 1, 8'hB0, 0);
    cycle();
    b_valid = 1'b0;
    wait_dv("t3_dummy");
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1;
      a_data  = 8'hA1 + 8'(i);
      cycle();
      if (i == 3) check("t3_full_after4", a_ready, 0);
    end
    a_valid = 1'b0;
    check("t3_still_full", a_ready, 0);
    ack_once();
    wait_dv("t3_next");
    check("t3_ready_back", a_ready, 1);
    check("t3_first_a", data, 8'hA1);
    repeat (4) serve(1);
    repeat (5) cycle();
    exp_q.delete();
    exp_q.push_back(8'hB0);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hA1 + 8'(i));
    check_order("t3_order");
    check("t3_busy", busy, 0);

    // Push and pop on the same edge with two bytes held in A.
    emitted.delete();
    drive(0, 8'h00, 1, 8'hC0, 0);
    cycle();
    b_valid = 1'b0;
    wait_dv("t4_dummy");
    drive(1, 8'h31, 0, 8'h00, 0);
    cycle();
    a_data = 8'h32;
    cycle();
    a_valid = 1'b0;
    ack_once();
    cycle();
    drive(1, 8'h33, 0, 8'h00, 0);
    cycle();
    check("t4_popped_dv", data_valid, 1);
    check("t4_popped_data", data, 8'h31);
    a_data = 8'h34;
    cycle();
    check("t4_ready_at3", a_ready, 1);
    a_data = 8'h35;
    cycle();
    check("t4_full_at4", a_ready, 0);
    a_valid = 1'b0;
    repeat (5) serve(1);
    repeat (3) cycle();
    exp_q.delete();
    exp_q.push_back(8'hC0);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h31 + 8'(i));
    check_order("t4_order");

    // Stray acks in IDLE (empty), in GAP, and on the IDLE grant edge.
    emitted.delete();
    tx_ack = 1'b1;
    cycle();
    tx_ack = 1'b0;
    check("t5_idle_dv", data_valid, 0);
    check("t5_idle_busy", busy, 0);
    drive(1, 8'h51, 0, 8'h00, 0);
    cycle();
    a_data = 8'h52;
    cycle();
    a_valid = 1'b0;
    wait_dv("t5_first");
    tx_ack = 1'b1;
    repeat (3) cycle();
    tx_ack = 1'b0;
    check("t5_no_pop_dv", data_valid, 1);
    check("t5_no_pop_data", data, 8'h52);
    cycle();
    check("t5_still_held", data_valid, 1);
    ack_once();
    repeat (3) cycle();
    exp_q.delete();
    exp_q.push_back(8'h51);
    exp_q.push_back(8'h52);
    check_order("t5_order");

    // Reset asserted mid-presentation with three bytes queued.
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'h41 + 8'(i), 0, 8'h00, 0);
      cycle();
    end
    a_valid = 1'b0;
    check("t6_presenting", data_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("t6_async_dv", data_valid, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_data", data, 8'h00);
    check("t6_async_ready", a_ready, 1);
    compare_outputs();
    repeat (2) cycle();
    rst = 1'b0;
    emitted.delete();
    repeat (8) cycle();
    check("t6_quiet_busy", busy, 0);
    check("t6_quiet_dv", data_valid, 0);
    drive(1, 8'h61, 0, 8'h00, 0);
    cycle();
    a_valid = 1'b0;
    wait_dv("t6_new");
    check("t6_new_data", data, 8'h61);
    ack_once();
    repeat (2) cycle();
    exp_q.delete();
    exp_q.push_back(8'h61);
    check_order("t6_order");

    // Randomized traffic at several load levels, checked cycle by cycle against the model.
    for (int blk = 0; blk < 6; blk++) begin
      pa = $urandom_range(10, 90);
      pb = $urandom_range(10, 90);
      pk = $urandom_range(15, 80);
      for (int c = 0; c < 500; c++) begin
        drive(($urandom % 100) < pa, 8'($urandom), ($urandom % 100) < pb, 8'($urandom),
              ($urandom % 100) < pk);
        cycle();
      end
    end
    drive(0, 8'h00, 0, 8'h00, 0);
    n = 0;
    while (busy && n < 500) begin
      tx_ack = 1'($urandom);
      cycle();
      n++;
    end
    tx_ack = 1'b0;
    check("drain_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
